// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches words over a req/ack memory handshake into a small FIFO
// and presents the head instruction with its PC and PC+4 to the IF/ID stage.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     consume,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [31:0]              next_pc_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [31:0]     pending_pc_reg, pending_pc_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW:0]     count_after;
    logic [31:0]     target_pc;
    logic            push, pop, flush;

    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign flush       = redirect;
    assign inst_valid  = (count_reg != '0);
    assign pop         = consume && inst_valid && !redirect;
    // Occupancy after a push in the current cycle, one bit wider so DEPTH itself is representable.
    assign count_after = {1'b0, count_reg} + (CW+1)'(1) - (CW+1)'(pop);

    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        pending_pc_next = pending_pc_reg;
        push            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end else if (count_reg < DEPTH_C) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack && redirect) begin
                    fetch_pc_next = target_pc;
                    state_next    = IDLE;
                end else if (imem_ack) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    if (count_after >= DEPTH_X) begin
                        state_next = IDLE;
                    end
                end else if (redirect) begin
                    // Request stays outstanding on the old address; the target waits in pending_pc.
                    pending_pc_next = target_pc;
                    state_next      = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    fetch_pc_next = redirect ? target_pc : pending_pc_reg;
                    state_next    = IDLE;
                end else if (redirect) begin
                    pending_pc_next = target_pc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            pending_pc_reg <= pending_pc_next;
            count_reg      <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Storage needs no reset: the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
        end
    end

    assign imem_req    = (state_reg != IDLE);
    assign imem_addr   = fetch_pc_reg;
    assign inst_out    = inst_valid ? data_mem[rd_ptr_reg] : 32'h0;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_reg] : 32'h0;
    assign next_pc_out = inst_valid ? (pc_mem[rd_ptr_reg] + 32'd4) : 32'h0;
    assign count       = count_reg;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a variable-latency memory responder feeds a scoreboard of
// {pc, data} entries which are compared as the pipeline consumes the queue head.
module tb_ifetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] next_pc_out;
    logic [2:0]  count;

    int     errors = 0;
    int     checks = 0;
    int     pop_cnt = 0;
    int     lat = 0;
    int     wait_cnt = 0;
    bit     sb_accept = 1'b1;
    entry_t exp_q[$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .consume(consume), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_out(inst_out), .inst_pc(inst_pc), .next_pc_out(next_pc_out), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F96;
    endfunction

    // Memory responder: acks after `lat` wait cycles; accepted data is pushed to the scoreboard.
    always @(negedge clk) begin
        if (!imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            wait_cnt   = 0;
        end else if (wait_cnt >= lat) begin
            entry_t e;
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt   = 0;
            e.pc   = imem_addr;
            e.data = mem_word(imem_addr);
            if (sb_accept) exp_q.push_back(e);
            $display("ack  addr=%h data=%h", imem_addr, imem_rdata);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt++;
        end
    end

    // Scoreboard consumer: every head taken by the pipeline must match the oldest accepted fetch.
    always @(negedge clk) begin
        if (reset && consume && inst_valid && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got pc=%h with no entry expected", inst_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst_out !== e.data || next_pc_out !== e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL sb_head: got pc=%h inst=%h npc=%h want pc=%h inst=%h npc=%h",
                             inst_pc, inst_out, next_pc_out, e.pc, e.data, e.pc + 32'd4);
                end else begin
                    $display("pop  pc=%h inst=%h", inst_pc, inst_out);
                end
            end
            pop_cnt++;
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        consume = 1'b0;
        sb_accept = 1'b1;
        lat = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pop_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        consume = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst_out !== 32'h0 ||
            inst_pc !== 32'h0 || next_pc_out !== 32'h0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b inst=%h pc=%h npc=%h count=%0d want all zero",
                     imem_req, imem_addr, inst_valid, inst_out, inst_pc, next_pc_out, count);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        consume = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stream_first_idle: req=%b want 0", imem_req);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || count > 3'd1) begin
                errors++;
                $display("FAIL stream_addr[%0d]: req=%b addr=%h count=%0d want req=1 addr=%h count<=1",
                         i, imem_req, imem_addr, count, 32'(4 * i));
            end
        end
        @(posedge clk);
        #1 consume = 1'b0;
        checks++;
        if (pop_cnt !== 9) begin
            errors++;
            $display("FAIL stream_pops: got %0d want 9", pop_cnt);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL fill_addr[%0d]: req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i));
            end
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || count !== 3'd4 || inst_pc !== 32'h0 || inst_out !== mem_word(32'h0)) begin
                errors++;
                $display("FAIL fill_full: req=%b count=%0d pc=%h inst=%h want req=0 count=4 pc=0 inst=%h",
                         imem_req, count, inst_pc, inst_out, mem_word(32'h0));
            end
        end
        @(posedge clk);
        #1 consume = 1'b1;
        @(posedge clk);
        #1 consume = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd3 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fill_after_pop: count=%0d req=%b want count=3 req=0", count, imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL fill_refetch: req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || count !== 3'd4 || inst_pc !== 32'h4) begin
            errors++;
            $display("FAIL fill_refull: req=%b count=%0d pc=%h want req=0 count=4 pc=00000004", imem_req, count, inst_pc);
        end
    endtask

    task automatic test_drain();
        bit found = 1'b0;
        apply_reset();
        lat = 3;
        consume = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drain_wait_req8: timeout, addr=%h want 00000008", imem_addr);
        end
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        sb_accept = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL drain_hold0: req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr);
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold[%0d]: req=%b addr=%h valid=%b want req=1 addr=00000008 valid=0",
                         k, imem_req, imem_addr, inst_valid);
            end
        end
        @(posedge clk);
        #1 sb_accept = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: req=%b addr=%h valid=%b want req=0 addr=00000100 valid=0",
                     imem_req, imem_addr, inst_valid);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 32'h100) begin
            errors++;
            $display("FAIL drain_first_pc: valid=%b pc=%h want valid=1 pc=00000100", inst_valid, inst_pc);
        end
        @(posedge clk);
        #1 consume = 1'b0;
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL rack_prefill: count=%0d want 1", count);
        end
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        consume = 1'b1;
        sb_accept = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL rack_before: count=%0d req=%b addr=%h want count=2 req=1 addr=00000008",
                     count, imem_req, imem_addr);
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        consume = 1'b0;
        sb_accept = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL rack_flush: count=%0d valid=%b req=%b addr=%h want count=0 valid=0 req=0 addr=00000040",
                     count, inst_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL rack_refetch: req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd1 || inst_pc !== 32'h40 || inst_out !== mem_word(32'h40)) begin
            errors++;
            $display("FAIL rack_first: count=%0d pc=%h inst=%h want count=1 pc=00000040 inst=%h",
                     count, inst_pc, inst_out, mem_word(32'h40));
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        lat = 2;
        repeat (5) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: req=%b addr=%h valid=%b want req=1 addr=00000004 valid=1",
                     imem_req, imem_addr, inst_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0 || inst_out !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_now: req=%b valid=%b count=%0d inst=%h addr=%h want all zero",
                     imem_req, inst_valid, count, inst_out, imem_addr);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: req=%b want 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_restart: req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFD;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_load: req=%b addr=%h want req=0 addr=fffffffc", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || next_pc_out !== 32'h0 ||
            inst_out !== mem_word(32'hFFFF_FFFC) || count !== 3'd1) begin
            errors++;
            $display("FAIL wrap_head: addr=%h pc=%h npc=%h inst=%h count=%0d want addr=0 pc=fffffffc npc=0 inst=%h count=1",
                     imem_addr, inst_pc, next_pc_out, inst_out, count, mem_word(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_drain();
        test_redirect_ack();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
